// File: rtl/mac_rx_ingress_arb.sv
// rtl/mac_rx_ingress_arb.sv - drains best-effort and TTE MAC RX queues, arbitrates per frame,
// drops bad frames and streams accepted frames bytewise with valid/ready.
module mac_rx_ingress_arb #(
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1518,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_empty,
  output logic        tte_fifo_rd,
  input  logic [7:0]  tte_fifo_dout,
  output logic        tteptr_fifo_rd,
  input  logic [15:0] tteptr_fifo_dout,
  input  logic        tteptr_fifo_empty,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_tte,
  output logic [11:0] out_len,
  output logic [15:0] drop_cnt,
  output logic        busy
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PTR    = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_XFER   = 3'd3;
  localparam logic [2:0] S_DROP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);

  logic [2:0]    r_state;
  logic          r_tte;
  logic          r_err;
  logic [11:0]   r_len;
  logic [11:0]   r_rd_left;
  logic [11:0]   r_out_cnt;
  logic [SW-1:0] r_starve;
  logic          r_inflight;
  logic [7:0]    r_skid [2];
  logic [1:0]    r_skid_cnt;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          r_sof;
  logic          r_eof;
  logic [15:0]   r_drop_cnt;

  logic       w_grant_tte, w_grant_be, w_bad, w_accept, w_load;
  logic       w_xfer_rd, w_drop_rd, w_data_rd, w_push, w_pop;
  logic [2:0] w_occ;
  logic [7:0] w_din, w_head;
  logic       w_unused;

  // Reserved descriptor bits carry nothing this block needs.
  assign w_unused = ^{ptr_fifo_dout[14:12], tteptr_fifo_dout[14:12]};

  // Grant is combinational in IDLE so the ptr read lands in the sampling cycle; gated by rstn
  // so that every output is low while reset is held.
  assign w_grant_tte = (r_state == S_IDLE) && rstn && !tteptr_fifo_empty &&
                       (ptr_fifo_empty || (r_starve < STARVE_MAX));
  assign w_grant_be  = (r_state == S_IDLE) && rstn && !ptr_fifo_empty && !w_grant_tte;

  assign w_bad    = r_err || (r_len < MIN_L) || (r_len > MAX_L);
  assign w_accept = r_valid && out_ready;
  assign w_din    = r_tte ? tte_fifo_dout : data_fifo_dout;
  assign w_head   = (r_skid_cnt != 2'd0) ? r_skid[0] : w_din;
  assign w_load   = (r_state == S_XFER) && ((r_skid_cnt != 2'd0) || r_inflight) &&
                    (!r_valid || w_accept);

  // Bytes held or owed after this cycle's accept; the output register counts as storage so
  // reads never run more than two ahead of accepts.
  assign w_occ = {2'b00, r_valid} + {1'b0, r_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_accept};

  assign w_xfer_rd = (((r_state == S_DECIDE) && !w_bad) || (r_state == S_XFER)) &&
                     (r_rd_left != 12'd0) && (w_occ < 3'd2);
  assign w_drop_rd = (r_state == S_DROP) && (r_rd_left != 12'd0);
  assign w_data_rd = w_xfer_rd || w_drop_rd;
  assign w_pop     = w_load && (r_skid_cnt != 2'd0);
  assign w_push    = r_inflight && !(w_load && (r_skid_cnt == 2'd0));

  assign data_fifo_rd   = w_data_rd && !r_tte;
  assign tte_fifo_rd    = w_data_rd && r_tte;
  assign ptr_fifo_rd    = w_grant_be;
  assign tteptr_fifo_rd = w_grant_tte;
  assign out_valid      = r_valid;
  assign out_data       = r_data;
  assign out_sof        = r_sof;
  assign out_eof        = r_eof;
  assign out_tte        = r_tte;
  assign out_len        = r_len;
  assign drop_cnt       = r_drop_cnt;
  assign busy           = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_tte      <= 1'b0;
      r_err      <= 1'b0;
      r_len      <= 12'd0;
      r_rd_left  <= 12'd0;
      r_starve   <= '0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (w_data_rd) r_rd_left <= r_rd_left - 12'd1;
      case (r_state)
        S_IDLE: begin
          if (w_grant_tte) begin
            r_tte   <= 1'b1;
            r_state <= S_PTR;
            if (!ptr_fifo_empty) r_starve <= r_starve + 1'b1;
          end else if (w_grant_be) begin
            r_tte    <= 1'b0;
            r_state  <= S_PTR;
            r_starve <= '0;
          end
        end
        S_PTR: begin
          r_err     <= r_tte ? tteptr_fifo_dout[15] : ptr_fifo_dout[15];
          r_len     <= r_tte ? tteptr_fifo_dout[11:0] : ptr_fifo_dout[11:0];
          r_rd_left <= r_tte ? tteptr_fifo_dout[11:0] : ptr_fifo_dout[11:0];
          r_state   <= S_DECIDE;
        end
        S_DECIDE: begin
          if (w_bad) begin
            r_state <= S_DROP;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
          end else begin
            r_state <= S_XFER;
          end
        end
        S_XFER:  if (w_accept && r_eof) r_state <= S_DONE;
        S_DROP:  if (r_rd_left <= 12'd1) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= 1'b0;
      r_skid[0]  <= 8'd0;
      r_skid[1]  <= 8'd0;
      r_skid_cnt <= 2'd0;
      r_valid    <= 1'b0;
      r_data     <= 8'd0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_out_cnt  <= 12'd0;
    end else begin
      r_inflight <= w_xfer_rd;
      if (r_state == S_PTR) r_out_cnt <= 12'd0;
      if (w_push && !w_pop) begin
        r_skid[r_skid_cnt[0]] <= w_din;
        r_skid_cnt            <= r_skid_cnt + 2'd1;
      end else if (w_pop && !w_push) begin
        r_skid[0]  <= r_skid[1];
        r_skid_cnt <= r_skid_cnt - 2'd1;
      end else if (w_push && w_pop) begin
        if (r_skid_cnt == 2'd1) begin
          r_skid[0] <= w_din;
        end else begin
          r_skid[0] <= r_skid[1];
          r_skid[1] <= w_din;
        end
      end
      if (w_load) begin
        r_valid   <= 1'b1;
        r_data    <= w_head;
        r_sof     <= (r_out_cnt == 12'd0);
        r_eof     <= (r_out_cnt == r_len - 12'd1);
        r_out_cnt <= r_out_cnt + 12'd1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/mac_rx_ingress_arb.md
Name: mac_rx_ingress_arb

Overview:
- Sits directly downstream of the GMII MAC receive path. Drains the MAC's two RX queues, best-effort (data + ptr FIFO) and TTE (tte + tteptr FIFO).
- Arbitrates between them at frame boundaries, discards errored or out-of-range frames, and streams accepted frames bytewise to the switch ingress with valid/ready handshaking.
- All MAC RX FIFOs are standard read-latency-1 FIFOs: dout is valid the cycle after rd.

Parameters:
- MIN_LEN, 64: smallest accepted frame length in bytes.
- MAX_LEN, 1518: largest accepted frame length in bytes.
- STARVE_LIMIT, 4: consecutive TTE frames granted while best-effort is pending before one best-effort frame is forced.

Ports:
- clk  in  1  system clock. Same clk as the MAC system side.
- rstn  in  1  asynchronous active-low reset.
- data_fifo_rd  out  1  best-effort data FIFO read strobe.
- data_fifo_dout  in  8  best-effort frame byte.
- ptr_fifo_rd  out  1  best-effort pointer FIFO read strobe.
- ptr_fifo_dout  in  16  best-effort descriptor: [15] error flag, [14:12] reserved, [11:0] byte length.
- ptr_fifo_empty  in  1  best-effort pointer FIFO empty.
- tte_fifo_rd  out  1  TTE data FIFO read strobe.
- tte_fifo_dout  in  8  TTE frame byte.
- tteptr_fifo_rd  out  1  TTE pointer FIFO read strobe.
- tteptr_fifo_dout  in  16  TTE descriptor, same format as ptr_fifo_dout.
- tteptr_fifo_empty  in  1  TTE pointer FIFO empty.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the byte when high together with out_valid.
- out_data  out  8  frame byte.
- out_sof  out  1  first byte of frame.
- out_eof  out  1  last byte of frame.
- out_tte  out  1  frame class; constant for the whole frame.
- out_len  out  12  frame length; valid whenever out_valid is high.
- drop_cnt  out  16  count of discarded frames; saturates at 0xFFFF.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (asynchronous on rstn low): every output is 0, state is IDLE, skid buffer is empty, starve counter is 0, drop_cnt is 0.
- Reset mid-frame returns to IDLE immediately. FIFOs are not flushed by this block; the MAC shares rstn.
- States: IDLE, PTR, DECIDE, XFER, DROP, DONE.
- IDLE, grant selection:
  - If tteptr is non-empty and (ptr is empty or starve < STARVE_LIMIT), grant TTE.
  - Otherwise, if ptr is non-empty, grant best-effort.
  - On grant, pulse the matching ptr rd for exactly 1 cycle (T0) and go to PTR.
- Starve counter:
  - Increments on a TTE grant made while ptr_fifo_empty = 0.
  - Clears on any best-effort grant.
  - Holds while best-effort is empty.
- PTR (T1): latch the descriptor; go to DECIDE.
- DECIDE (T2):
  - If err = 1, or len < MIN_LEN, or len > MAX_LEN: go to DROP and increment drop_cnt (saturating).
  - Otherwise go to XFER. len = 0 is always dropped.
- XFER:
  - Byte counters: rd_left counts down from len; the read for the first byte is issued at T2.
  - Data rd is pulsed when rd_left > 0 and (skid occupancy + reads in flight) < 2.
  - Returned bytes enter a 2-entry skid buffer. Output registers load from the skid head.
  - The first out_valid appears at T4.
  - Sustains 1 byte/cycle while out_ready stays high.
  - out_sof is high on byte 1 only; out_eof is high on byte len only.
  - out_data, out_sof and out_eof hold stable while out_valid is high and out_ready is low.
  - Go to DONE after the eof byte is accepted.
- DROP:
  - Pulse data rd every cycle for exactly len cycles, independent of out_ready.
  - out_valid stays 0. Then go to DONE.
- DONE: one idle cycle; return to IDLE. The minimum inter-frame gap is therefore 1 cycle before the next ptr rd.
- Only the granted class's data rd may pulse. Both ptr rds must never be high in the same cycle.
- Empty flags are sampled only in IDLE. Arrivals during a frame are served at the next IDLE.
- Any rd issued while the matching empty flag is set is a protocol violation. The block never issues a ptr rd while empty. Data FIFO occupancy is guaranteed by the descriptor.

Test Plan:
- Single best-effort frame, len = 64, bytes 0x00..0x3F, out_ready = 1:
  - ptr_fifo_rd pulses at T0; out_valid rises at T4.
  - 64 consecutive beats; sof on 0x00, eof on 0x3F, out_tte = 0.
  - drop_cnt stays 0; busy falls 2 cycles after eof.
- Backpressure: len = 100, out_ready toggled 1/0 every cycle:
  - All 100 bytes delivered in order with none duplicated.
  - data_fifo_rd never pulses more than 2 times ahead of accepts.
- Drop handling: descriptors 0x8040 (err set), 0x0020 (len 32), 0x05FF (len 1535):
  - data_fifo_rd pulses exactly 64, 32 and 1535 times respectively.
  - out_valid stays 0; drop_cnt = 3.
  - A following good frame is delivered intact.
- Priority and starvation, STARVE_LIMIT = 4: both queues loaded with 6 TTE and 2 best-effort frames, len 64:
  - Grant order is T,T,T,T,B,T,T,B.
- Simultaneous arrival: both empty flags fall in the same IDLE cycle:
  - TTE is granted; tteptr_fifo_rd = 1 and ptr_fifo_rd = 0 in that cycle.
- Reset mid-frame: assert rstn low at byte 30 of a 200-byte frame:
  - All outputs go to 0 within the same cycle; state is IDLE and drop_cnt = 0 after release.
